seq_divider: RTL and testbench

Multi-cycle 32-bit divider producing quotient and remainder, one quotient bit per clock, using non-restoring division. It is the inverse-direction companion of the datapath carry-lookahead adder: every iteration is a single add or subtract of the divisor. It sits beside the ALU and feeds the LO (quotient) and HI (remainder) registers through a start/done handshake driven by the control unit.

---
 rtl/seq_divider_pkg.sv | 22 ++
 rtl/seq_divider_if.sv | 33 +++
 rtl/seq_divider_addsub.sv | 24 ++
 rtl/seq_divider.sv | 190 +++++++++++++++++++
 tb/tb_seq_divider.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg: shared types and constants for the sequential divider.
//   div_state_e       : FSM state encoding (IDLE, ITER, FIX)
//   DIV_WIDTH_DEFAULT : default operand/result width
//   cnt_width()       : width of the iteration counter for a given WIDTH
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // The counter counts WIDTH-1 down to 0, so $clog2(WIDTH) bits are enough.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if: start/done handshake and operand/result bus of seq_divider.
//   start, dividend, divisor          : control unit -> divider
//   busy, done, quotient, remainder,
//   div_by_zero                       : divider -> control unit
// Modports: master (control unit side), slave (divider side).
// -----------------------------------------------------------------------------
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_addsub.sv
// -----------------------------------------------------------------------------
// div_addsub: N-bit adder/subtractor used by the divider's iteration and
// remainder-correction steps.
//   a, b : operands
//   sub  : 0 -> y = a + b, 1 -> y = a - b
//   y    : result (modulo 2^N)
// Subtraction reuses the adder: the b operand is inverted and sub is fed in as
// the carry-in.
// -----------------------------------------------------------------------------
module div_addsub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y
);

  logic [N-1:0] b_eff;

  assign b_eff = b ^ {N{sub}};
  assign y     = a + b_eff + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider: multi-cycle non-restoring divider, one quotient bit per clock.
//   clock : rising-edge clock
//   clear : asynchronous active-high reset
//   bus   : seq_divider_if.slave (start, dividend, divisor in;
//           busy, done, quotient, remainder, div_by_zero out)
// Optional feature macro: DIV_SIGNED_EN -- when defined, operands are two's
// complement (quotient truncates toward zero, remainder takes the dividend's
// sign); when undefined the divider is unsigned and has no sign logic.
// Latency: start accepted at edge E0, done pulses for the cycle after
// E(WIDTH+1); a zero divisor skips iteration and completes after E1.
// -----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic          clock,
  input  logic          clear,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e       state_reg, state_next;

  logic [WIDTH:0]   r_reg;        // partial remainder, signed, one guard bit
  logic [WIDTH-1:0] q_reg;        // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] d_reg;        // divisor magnitude
  logic [CNT_W-1:0] cnt_reg;
  logic             dz_reg;       // divisor was zero at acceptance

  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_by_zero_reg;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted_r, as_a, as_b, as_y;
  logic             as_sub;
  logic [WIDTH-1:0] q_mag, r_mag, q_final, r_final;

`ifdef DIV_SIGNED_EN
  logic             neg_q_reg, neg_r_reg;

  assign dvd_mag = bus.dividend[WIDTH-1] ? (WIDTH'(0) - bus.dividend) : bus.dividend;
  assign dvs_mag = bus.divisor[WIDTH-1]  ? (WIDTH'(0) - bus.divisor)  : bus.divisor;
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
`endif

  // ---------------------------------------------------------------------------
  // Shared adder/subtractor. In ITER it works on the shifted remainder and the
  // operation is chosen by the sign of R before the shift; in FIX it adds D back
  // (only used when R ended negative).
  // ---------------------------------------------------------------------------
  assign shifted_r = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign as_b      = {1'b0, d_reg};

  always_comb begin
    as_a   = shifted_r;
    as_sub = ~r_reg[WIDTH];
    if (state_reg == FIX) begin
      as_a   = r_reg;
      as_sub = 1'b0;
    end
  end

  div_addsub #(
    .N (WIDTH + 1)
  ) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .y   (as_y)
  );

  // ---------------------------------------------------------------------------
  // Result formation in FIX. For a zero divisor q_reg still holds the dividend
  // magnitude, so restoring its sign reproduces the original dividend.
  // ---------------------------------------------------------------------------
  always_comb begin
    q_mag = dz_reg ? {WIDTH{1'b1}} : q_reg;
    r_mag = dz_reg ? q_reg : (r_reg[WIDTH] ? as_y[WIDTH-1:0] : r_reg[WIDTH-1:0]);
`ifdef DIV_SIGNED_EN
    q_final = (neg_q_reg && !dz_reg) ? (WIDTH'(0) - q_mag) : q_mag;
    r_final = neg_r_reg ? (WIDTH'(0) - r_mag) : r_mag;
`else
    q_final = q_mag;
    r_final = r_mag;
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and status outputs. The done cycle is spent in IDLE, so a
  // start there is accepted like any other idle start.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    bus.busy   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.divisor == '0) ? FIX : ITER;
        end
      end
      ITER: begin
        bus.busy = 1'b1;
        if (cnt_reg == '0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        bus.busy   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_reg           <= '0;
      q_reg           <= '0;
      d_reg           <= '0;
      cnt_reg         <= '0;
      dz_reg          <= 1'b0;
      done_reg        <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_reg       <= 1'b0;
      neg_r_reg       <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            r_reg   <= '0;
            q_reg   <= dvd_mag;
            d_reg   <= dvs_mag;
            cnt_reg <= CNT_W'(WIDTH - 1);
            dz_reg  <= (bus.divisor == '0);
`ifdef DIV_SIGNED_EN
            neg_q_reg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r_reg <= bus.dividend[WIDTH-1];
`endif
          end
        end
        ITER: begin
          r_reg   <= as_y;
          q_reg   <= {q_reg[WIDTH-2:0], ~as_y[WIDTH]};
          cnt_reg <= cnt_reg - 1'b1;
        end
        FIX: begin
          quotient_reg    <= q_final;
          remainder_reg   <= r_final;
          div_by_zero_reg <= dz_reg;
          done_reg        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider: directed self-checking bench for seq_divider (WIDTH = 32).
// Expected values are hand-computed; the signed/unsigned variants follow the
// DIV_SIGNED_EN macro.
// -----------------------------------------------------------------------------
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 32;

  logic clock;
  logic clear;
  int   checks;
  int   failures;

  seq_divider_if #(.WIDTH(W)) dif ();

  seq_divider #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (dif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Starts one division from the current time (not at an edge), accepts it on
  // the next rising edge, scrambles the operand inputs afterwards, and waits
  // up to 100 edges for done. lat = 0 means no done was seen.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat, output int busy_cnt,
                         output int overlap);
    dif.dividend = a;
    dif.divisor  = b;
    dif.start    = 1'b1;
    @(posedge clock);
    #1;
    dif.start    = 1'b0;
    dif.dividend = ~a;
    dif.divisor  = b ^ 32'h5A5A_5A5A;
    busy_cnt = dif.busy ? 1 : 0;
    lat      = 0;
    overlap  = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (dif.busy && dif.done) overlap++;
      if (dif.busy) busy_cnt++;
      if (dif.done) begin
        lat = n;
        break;
      end
    end
    q  = dif.quotient;
    r  = dif.remainder;
    dz = dif.div_by_zero;
    $display("div %h / %h -> q=%h r=%h dz=%b lat=%0d busy=%0d", a, b, q, r, dz, lat, busy_cnt);
  endtask

  task automatic test_reset();
    clear        = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b done=%b dz=%b, required 0 0 0", dif.busy, dif.done, dif.div_by_zero);
    end
    checks++;
    if (dif.quotient !== 32'h0 || dif.remainder !== 32'h0) begin
      failures++;
      $display("FAIL reset_results: q=%h r=%h, required 0 0", dif.quotient, dif.remainder);
    end
    @(negedge clock);
    clear = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic();
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic [W-1:0] eq [8];
    logic [W-1:0] er [8];
    logic [W-1:0] q, r;
    logic         dz;
    int           lat, bc, ov;
    va[0] = 32'd100;       vb[0] = 32'd7;          eq[0] = 32'd14;        er[0] = 32'd2;
    va[1] = 32'd7;         vb[1] = 32'd9;          eq[1] = 32'd0;         er[1] = 32'd7;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'd1;          eq[2] = 32'hFFFF_FFFF; er[2] = 32'd0;
`ifdef DIV_SIGNED_EN
    va[3] = 32'hFFFF_FFF9; vb[3] = 32'd2;          eq[3] = 32'hFFFF_FFFD; er[3] = 32'hFFFF_FFFF;
    va[4] = 32'h8000_0000; vb[4] = 32'hFFFF_FFFF;  eq[4] = 32'h8000_0000; er[4] = 32'd0;
    va[5] = 32'hDEAD_BEEF; vb[5] = 32'h10;         eq[5] = 32'hFDEA_DBEF; er[5] = 32'hFFFF_FFFF;
    va[6] = 32'd100;       vb[6] = 32'hFFFF_FFF9;  eq[6] = 32'hFFFF_FFF2; er[6] = 32'd2;
`else
    va[3] = 32'hFFFF_FFF9; vb[3] = 32'd2;          eq[3] = 32'h7FFF_FFFC; er[3] = 32'd1;
    va[4] = 32'h8000_0000; vb[4] = 32'hFFFF_FFFF;  eq[4] = 32'd0;         er[4] = 32'h8000_0000;
    va[5] = 32'hDEAD_BEEF; vb[5] = 32'h10;         eq[5] = 32'h0DEA_DBEE; er[5] = 32'hF;
    va[6] = 32'd100;       vb[6] = 32'hFFFF_FFF9;  eq[6] = 32'd0;         er[6] = 32'd100;
`endif
    va[7] = 32'd1000;      vb[7] = 32'd3;          eq[7] = 32'd333;       er[7] = 32'd1;
    for (int i = 0; i < 8; i++) begin
      run_div(va[i], vb[i], q, r, dz, lat, bc, ov);
      checks++;
      if (lat !== 33) begin
        failures++;
        $display("FAIL basic_latency[%0d]: got %0d edges, required 33", i, lat);
      end
      checks++;
      if (bc !== 33) begin
        failures++;
        $display("FAIL basic_busy[%0d]: busy for %0d cycles, required 33", i, bc);
      end
      checks++;
      if (ov !== 0) begin
        failures++;
        $display("FAIL basic_overlap[%0d]: busy&done %0d cycles, required 0", i, ov);
      end
      checks++;
      if (q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
        failures++;
        $display("FAIL basic_result[%0d]: q=%h r=%h dz=%b, required q=%h r=%h dz=0", i, q, r, dz, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic         dz;
    int           lat, bc, ov;
    run_div(32'd5, 32'd0, q, r, dz, lat, bc, ov);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL dz_latency: got %0d edges, required 1", lat);
    end
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd5 || dz !== 1'b1) begin
      failures++;
      $display("FAIL dz_result: q=%h r=%h dz=%b, required ffffffff 00000005 1", q, r, dz);
    end
    run_div(32'hFFFF_FFFB, 32'd0, q, r, dz, lat, bc, ov);
    checks++;
    if (lat !== 1 || ov !== 0 || q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFFB || dz !== 1'b1) begin
      failures++;
      $display("FAIL dz_neg: lat=%0d ov=%0d q=%h r=%h dz=%b, required 1 0 ffffffff fffffffb 1", lat, ov, q, r, dz);
    end
  endtask

  task automatic test_clear_mid();
    logic [W-1:0] q, r;
    logic         dz;
    int           lat, bc, ov;
    int           seen_done, seen_busy;
    dif.dividend = 32'd1000;
    dif.divisor  = 32'd3;
    dif.start    = 1'b1;
    @(posedge clock);
    #1;
    dif.start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    checks++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.div_by_zero !== 1'b0 ||
        dif.quotient !== 32'h0 || dif.remainder !== 32'h0) begin
      failures++;
      $display("FAIL clear_outputs: busy=%b done=%b dz=%b q=%h r=%h, required all 0",
               dif.busy, dif.done, dif.div_by_zero, dif.quotient, dif.remainder);
    end
    @(negedge clock);
    clear = 1'b0;
    seen_done = 0;
    seen_busy = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (dif.done) seen_done++;
      if (dif.busy) seen_busy++;
    end
    $display("clear during 1000 / 3: done seen %0d, busy seen %0d", seen_done, seen_busy);
    checks++;
    if (seen_done !== 0 || seen_busy !== 0) begin
      failures++;
      $display("FAIL clear_no_done: done %0d busy %0d cycles, required 0 0", seen_done, seen_busy);
    end
    run_div(32'd9, 32'd3, q, r, dz, lat, bc, ov);
    checks++;
    if (lat !== 33 || q !== 32'd3 || r !== 32'd0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL clear_after: lat=%0d q=%h r=%h dz=%b, required 33 3 0 0", lat, q, r, dz);
    end
  endtask

  task automatic test_ignore_start();
    int edges;
    dif.dividend = 32'd100;
    dif.divisor  = 32'd7;
    dif.start    = 1'b1;
    @(posedge clock);
    #1;
    dif.start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    dif.start    = 1'b1;
    dif.dividend = 32'd9;
    dif.divisor  = 32'd1;
    @(posedge clock);
    #1;
    dif.start = 1'b0;
    edges = 0;
    for (int n = 7; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (dif.done) begin
        edges = n;
        break;
      end
    end
    $display("div 100 / 7 with mid start -> q=%h r=%h lat=%0d", dif.quotient, dif.remainder, edges);
    checks++;
    if (edges !== 33) begin
      failures++;
      $display("FAIL ignore_latency: got %0d edges, required 33", edges);
    end
    checks++;
    if (dif.quotient !== 32'd14 || dif.remainder !== 32'd2) begin
      failures++;
      $display("FAIL ignore_result: q=%h r=%h, required 0000000e 00000002", dif.quotient, dif.remainder);
    end
    // Let the done cycle pass so the next test starts from plain IDLE.
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q, r;
    logic         dz;
    int           lat, bc, ov;
    logic         done_at_accept;
    run_div(32'd20, 32'd6, q, r, dz, lat, bc, ov);
    checks++;
    if (lat !== 33 || q !== 32'd3 || r !== 32'd2) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d q=%h r=%h, required 33 3 2", lat, q, r);
    end
    done_at_accept = dif.done;
    run_div(32'd50, 32'd5, q, r, dz, lat, bc, ov);
    checks++;
    if (done_at_accept !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done_cycle: done=%b at second start, required 1", done_at_accept);
    end
    checks++;
    if (lat !== 33 || q !== 32'd10 || r !== 32'd0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d q=%h r=%h dz=%b, required 33 a 0 0", lat, q, r, dz);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_clear_mid();
    test_ignore_start();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
